// File: rtl/reg_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter_pkg
// Shared definitions for the register write arbiter blocks: FSM state
// encoding, owner index width, lock counter width and a pointer-advance helper.
// -----------------------------------------------------------------------------
package reg_write_arbiter_pkg;

    // Owner / pointer index width; wide enough for up to 8 requesters.
    localparam int OWNER_W    = 3;
    // Lock counter width; holds MAX_LOCK values up to 255.
    localparam int LOCK_CNT_W = 8;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Round-robin successor of idx among count requesters.
    function automatic logic [OWNER_W-1:0] wrap_inc(input logic [OWNER_W-1:0] idx,
                                                   input int count);
        return (int'(idx) == count - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter_if
// Bundle of request and register-output signals between requesters and the
// arbiter.
//   req_i    : per-requester write request
//   lock_i   : per-requester lock request
//   data_i   : concatenated write data, requester k at [k*SIZE +: SIZE]
//   grant_o  : one-hot (or zero) combinational grant
//   data_o   : shared register contents
//   owner_o  : index of the most recent writer
//   valid_o  : at least one write since reset
//   locked_o : arbiter is in the LOCK state
// Modports: master (requester side), slave (arbiter side).
// -----------------------------------------------------------------------------
interface reg_write_arbiter_if
    import reg_write_arbiter_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int COUNT = 4
);
    logic [COUNT-1:0]      req_i;
    logic [COUNT-1:0]      lock_i;
    logic [COUNT*SIZE-1:0] data_i;
    logic [COUNT-1:0]      grant_o;
    logic [SIZE-1:0]       data_o;
    logic [OWNER_W-1:0]    owner_o;
    logic                  valid_o;
    logic                  locked_o;

    modport master (
        output req_i, lock_i, data_i,
        input  grant_o, data_o, owner_o, valid_o, locked_o
    );

    modport slave (
        input  req_i, lock_i, data_i,
        output grant_o, data_o, owner_o, valid_o, locked_o
    );
endinterface

// File: rtl/reg_write_arbiter_reg.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter_reg
// Parameterised register with write enable and synchronous clear.
//   clock    : rising-edge clock
//   reset    : synchronous active-high clear to zero
//   write_en : load d on the next edge
//   d        : write data
//   q        : stored value
// -----------------------------------------------------------------------------
module reg_write_arbiter_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             write_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // NOTE: sequential state is assigned with <= so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (write_en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
// Round-robin arbiter granting write access to one shared register, with an
// optional bounded lock that lets a requester keep the grant for up to
// MAX_LOCK consecutive cycles.
//   clock : rising-edge clock
//   reset : synchronous active-high reset; forces grant_o to zero while high
//   bus   : slave side of reg_write_arbiter_if (requests, data, grant, outputs)
// -----------------------------------------------------------------------------
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int SIZE     = 8,
    parameter int COUNT    = 4,
    parameter int MAX_LOCK = 16
) (
    input  logic               clock,
    input  logic               reset,
    reg_write_arbiter_if.slave bus
);
    state_t                  state, state_next;
    logic [OWNER_W-1:0]      ptr, ptr_next;
    logic [OWNER_W-1:0]      lock_owner, lock_owner_next;
    logic [LOCK_CNT_W-1:0]   lock_cnt, lock_cnt_next;

    logic                    hi_hit, lo_hit, arb_hit;
    logic [OWNER_W-1:0]      hi_idx, lo_idx, arb_idx, win_idx;
    logic [COUNT-1:0]        grant, owner_mask;
    logic                    owner_lock;
    logic [SIZE-1:0]         wdata;

    // Round-robin search: lowest requester at or above ptr wins; if none,
    // wrap and take the lowest requester overall.
    // NOTE: every variable written here gets a default first so no latch
    // is inferred on paths where the loop finds nothing.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int k = COUNT - 1; k >= 0; k--) begin
            if (bus.req_i[k]) begin
                lo_hit = 1'b1;
                lo_idx = OWNER_W'(k);
                if (k >= int'(ptr)) begin
                    hi_hit = 1'b1;
                    hi_idx = OWNER_W'(k);
                end
            end
        end
        arb_hit = hi_hit | lo_hit;
        arb_idx = hi_hit ? hi_idx : lo_idx;
    end

    assign owner_mask = COUNT'(1) << lock_owner;
    assign owner_lock = |(owner_mask & bus.lock_i);

    // FSM next state and grant.
    always_comb begin
        state_next      = state;
        ptr_next        = ptr;
        lock_owner_next = lock_owner;
        lock_cnt_next   = lock_cnt;
        grant           = '0;
        win_idx         = lock_owner;
        case (state)
            ARB: begin
                if (arb_hit) begin
                    grant    = COUNT'(1) << arb_idx;
                    win_idx  = arb_idx;
                    ptr_next = wrap_inc(arb_idx, COUNT);
                    if (|((COUNT'(1) << arb_idx) & bus.lock_i)) begin
                        state_next      = LOCK;
                        lock_owner_next = arb_idx;
                        lock_cnt_next   = LOCK_CNT_W'(1);
                    end
                end
            end
            LOCK: begin
                // Counter runs every locked cycle, even when the owner idles.
                lock_cnt_next = lock_cnt + 1'b1;
                // Lock release or exhausted budget: a dead cycle, then ARB
                // resumes with ptr still at owner+1.
                if (!owner_lock || lock_cnt == LOCK_CNT_W'(MAX_LOCK)) begin
                    state_next = ARB;
                end else begin
                    grant = owner_mask & bus.req_i;
                end
            end
            default: state_next = ARB;
        endcase
        if (reset) begin
            grant = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ARB;
            ptr        <= '0;
            lock_owner <= '0;
            lock_cnt   <= '0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            lock_owner <= lock_owner_next;
            lock_cnt   <= lock_cnt_next;
        end
    end

    // Write-data select driven from the grant vector only, so the grant
    // path never depends on data_i.
    always_comb begin
        wdata = '0;
        for (int k = 0; k < COUNT; k++) begin
            if (grant[k]) begin
                wdata = bus.data_i[k*SIZE +: SIZE];
            end
        end
    end

    reg_write_arbiter_reg #(.WIDTH(SIZE)) u_data (
        .clock(clock), .reset(reset), .write_en(|grant), .d(wdata), .q(bus.data_o)
    );

    reg_write_arbiter_reg #(.WIDTH(OWNER_W)) u_owner (
        .clock(clock), .reset(reset), .write_en(|grant), .d(win_idx), .q(bus.owner_o)
    );

    reg_write_arbiter_reg #(.WIDTH(1)) u_valid (
        .clock(clock), .reset(reset), .write_en(|grant), .d(1'b1), .q(bus.valid_o)
    );

    assign bus.grant_o  = grant;
    assign bus.locked_o = (state == LOCK);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_write_arbiter
// Directed self-checking bench. dut_a uses MAX_LOCK = 16; dut_b uses
// MAX_LOCK = 4 to exercise lock exhaustion. Inputs change 1 time unit after
// the rising edge; grants are sampled 1 unit later, registers 1 unit after
// the following edge.
// -----------------------------------------------------------------------------
module tb_reg_write_arbiter;
    logic clock;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;

    reg_write_arbiter_if #(.SIZE(8), .COUNT(4)) bus_a ();
    reg_write_arbiter_if #(.SIZE(8), .COUNT(4)) bus_b ();

    reg_write_arbiter #(.SIZE(8), .COUNT(4), .MAX_LOCK(16)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a.slave)
    );

    reg_write_arbiter #(.SIZE(8), .COUNT(4), .MAX_LOCK(4)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_a.req_i = '0; bus_a.lock_i = '0; bus_a.data_i = '0;
        bus_b.req_i = '0; bus_b.lock_i = '0; bus_b.data_i = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_a.req_i = 4'b1111; bus_a.lock_i = 4'b1111; bus_a.data_i = 32'h44332211;
        bus_b.req_i = 4'b1111; bus_b.lock_i = 4'b1111; bus_b.data_i = 32'h44332211;
        tick();
        vectors++; if (bus_a.grant_o !== 4'b0000) begin miscompares++; $display("FAIL reset_grant_a: got %b want 0000", bus_a.grant_o); end
        vectors++; if (bus_b.grant_o !== 4'b0000) begin miscompares++; $display("FAIL reset_grant_b: got %b want 0000", bus_b.grant_o); end
        tick();
        vectors++; if (bus_a.data_o !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", bus_a.data_o); end
        vectors++; if (bus_a.owner_o !== 3'd0) begin miscompares++; $display("FAIL reset_owner: got %0d want 0", bus_a.owner_o); end
        vectors++; if (bus_a.valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus_a.valid_o); end
        vectors++; if (bus_a.locked_o !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b want 0", bus_a.locked_o); end
        vectors++; if (bus_a.grant_o !== 4'b0000) begin miscompares++; $display("FAIL reset_hold_grant: got %b want 0000", bus_a.grant_o); end
    endtask

    task automatic test_round_robin();
        logic [7:0] slice [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        logic [3:0] want;
        do_reset();
        bus_a.req_i = 4'b1111; bus_a.lock_i = 4'b0000; bus_a.data_i = 32'hD4C3B2A1;
        for (int i = 0; i < 8; i++) begin
            want = 4'b0001 << (i % 4);
            #1;
            vectors++; if (bus_a.grant_o !== want) begin miscompares++; $display("FAIL rr_grant[%0d]: got %b want %b", i, bus_a.grant_o, want); end
            tick();
            vectors++; if (bus_a.data_o !== slice[i % 4]) begin miscompares++; $display("FAIL rr_data[%0d]: got %h want %h", i, bus_a.data_o, slice[i % 4]); end
            vectors++; if (bus_a.owner_o !== 3'(i % 4)) begin miscompares++; $display("FAIL rr_owner[%0d]: got %0d want %0d", i, bus_a.owner_o, i % 4); end
            vectors++; if (bus_a.valid_o !== 1'b1) begin miscompares++; $display("FAIL rr_valid[%0d]: got %b want 1", i, bus_a.valid_o); end
        end
    endtask

    task automatic test_sparse();
        logic [2:0] want_owner [3] = '{3'd1, 3'd3, 3'd1};
        logic [3:0] want;
        do_reset();
        bus_a.req_i = 4'b1010; bus_a.lock_i = 4'b0000; bus_a.data_i = 32'h44332211;
        for (int i = 0; i < 3; i++) begin
            want = 4'b0001 << want_owner[i];
            #1;
            vectors++; if (bus_a.grant_o !== want) begin miscompares++; $display("FAIL sparse_grant[%0d]: got %b want %b", i, bus_a.grant_o, want); end
            tick();
            vectors++; if (bus_a.owner_o !== want_owner[i]) begin miscompares++; $display("FAIL sparse_owner[%0d]: got %0d want %0d", i, bus_a.owner_o, want_owner[i]); end
        end
    endtask

    task automatic test_lock();
        do_reset();
        bus_a.req_i = 4'b1111; bus_a.lock_i = 4'b0000; bus_a.data_i = 32'h44332211;
        // Two plain grants move the pointer to 2.
        #1;
        vectors++; if (bus_a.grant_o !== 4'b0001) begin miscompares++; $display("FAIL lock_pre0: got %b want 0001", bus_a.grant_o); end
        tick();
        #1;
        vectors++; if (bus_a.grant_o !== 4'b0010) begin miscompares++; $display("FAIL lock_pre1: got %b want 0010", bus_a.grant_o); end
        tick();
        for (int i = 0; i < 5; i++) begin
            bus_a.lock_i = 4'b0100;
            bus_a.data_i = {8'h44, 8'h20 + 8'(i), 8'h22, 8'h11};
            #1;
            vectors++; if (bus_a.grant_o !== 4'b0100) begin miscompares++; $display("FAIL lock_grant[%0d]: got %b want 0100", i, bus_a.grant_o); end
            tick();
            vectors++; if (bus_a.data_o !== 8'h20 + 8'(i)) begin miscompares++; $display("FAIL lock_data[%0d]: got %h want %h", i, bus_a.data_o, 8'h20 + 8'(i)); end
            vectors++; if (bus_a.locked_o !== 1'b1) begin miscompares++; $display("FAIL lock_locked[%0d]: got %b want 1", i, bus_a.locked_o); end
        end
        bus_a.lock_i = 4'b0000;
        #1;
        vectors++; if (bus_a.grant_o !== 4'b0000) begin miscompares++; $display("FAIL lock_release_grant: got %b want 0000", bus_a.grant_o); end
        tick();
        vectors++; if (bus_a.locked_o !== 1'b0) begin miscompares++; $display("FAIL lock_release_locked: got %b want 0", bus_a.locked_o); end
        vectors++; if (bus_a.data_o !== 8'h24) begin miscompares++; $display("FAIL lock_release_data: got %h want 24", bus_a.data_o); end
        #1;
        vectors++; if (bus_a.grant_o !== 4'b1000) begin miscompares++; $display("FAIL lock_after_grant: got %b want 1000", bus_a.grant_o); end
        tick();
        vectors++; if (bus_a.owner_o !== 3'd3) begin miscompares++; $display("FAIL lock_after_owner: got %0d want 3", bus_a.owner_o); end
    endtask

    task automatic test_max_lock();
        // Four grants to 0, a forced-release cycle, then 1, 2, 3 before 0 again.
        logic [3:0] want [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                                 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        bus_b.req_i = 4'b1111; bus_b.lock_i = 4'b0001; bus_b.data_i = 32'h13121110;
        for (int i = 0; i < 9; i++) begin
            #1;
            vectors++; if (bus_b.grant_o !== want[i]) begin miscompares++; $display("FAIL maxlock_grant[%0d]: got %b want %b", i, bus_b.grant_o, want[i]); end
            if (i == 4) begin
                vectors++; if (bus_b.locked_o !== 1'b1) begin miscompares++; $display("FAIL maxlock_locked_last: got %b want 1", bus_b.locked_o); end
            end
            tick();
            if (i == 4) begin
                vectors++; if (bus_b.locked_o !== 1'b0) begin miscompares++; $display("FAIL maxlock_released: got %b want 0", bus_b.locked_o); end
                vectors++; if (bus_b.owner_o !== 3'd0) begin miscompares++; $display("FAIL maxlock_owner_hold: got %0d want 0", bus_b.owner_o); end
            end
        end
        vectors++; if (bus_b.data_o !== 8'h10) begin miscompares++; $display("FAIL maxlock_data: got %h want 10", bus_b.data_o); end
    endtask

    task automatic test_reset_in_lock();
        do_reset();
        bus_a.req_i = 4'b0001; bus_a.lock_i = 4'b0001; bus_a.data_i = 32'h443322A5;
        tick();
        vectors++; if (bus_a.data_o !== 8'hA5) begin miscompares++; $display("FAIL rstlock_data: got %h want a5", bus_a.data_o); end
        vectors++; if (bus_a.locked_o !== 1'b1) begin miscompares++; $display("FAIL rstlock_locked: got %b want 1", bus_a.locked_o); end
        tick();
        reset = 1'b1;
        bus_a.req_i = 4'b1111; bus_a.lock_i = 4'b1111;
        #1;
        vectors++; if (bus_a.grant_o !== 4'b0000) begin miscompares++; $display("FAIL rstlock_grant_in_reset: got %b want 0000", bus_a.grant_o); end
        tick();
        vectors++; if (bus_a.data_o !== 8'h00) begin miscompares++; $display("FAIL rstlock_data_cleared: got %h want 00", bus_a.data_o); end
        vectors++; if (bus_a.valid_o !== 1'b0) begin miscompares++; $display("FAIL rstlock_valid: got %b want 0", bus_a.valid_o); end
        vectors++; if (bus_a.locked_o !== 1'b0) begin miscompares++; $display("FAIL rstlock_locked_cleared: got %b want 0", bus_a.locked_o); end
        reset = 1'b0;
        bus_a.req_i = 4'b1110; bus_a.lock_i = 4'b0000;
        #1;
        vectors++; if (bus_a.grant_o !== 4'b0010) begin miscompares++; $display("FAIL rstlock_first_grant: got %b want 0010", bus_a.grant_o); end
        tick();
        vectors++; if (bus_a.data_o !== 8'h22) begin miscompares++; $display("FAIL rstlock_first_data: got %h want 22", bus_a.data_o); end
        vectors++; if (bus_a.owner_o !== 3'd1) begin miscompares++; $display("FAIL rstlock_first_owner: got %0d want 1", bus_a.owner_o); end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_round_robin();
        test_sparse();
        test_lock();
        test_max_lock();
        test_reset_in_lock();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
